// File: rtl/ws2812_stream_driver_if.sv
// Pixel-stream and strip-side signal bundle for the WS2812B transmitter.
// The pixel source (or a bench) takes the master side; the driver takes the slave side.
interface ws2812_stream_driver_if;
    logic        start;
    logic        pixValid;
    logic [23:0] pixData;
    logic [1:0]  dim;
    logic        pixReady;
    logic        bitOut;
    logic        busy;
    logic        frameDone;
    logic        underrun;

    modport master (
        output start,
        output pixValid,
        output pixData,
        output dim,
        input  pixReady,
        input  bitOut,
        input  busy,
        input  frameDone,
        input  underrun
    );

    modport slave (
        input  start,
        input  pixValid,
        input  pixData,
        input  dim,
        output pixReady,
        output bitOut,
        output busy,
        output frameDone,
        output underrun
    );
endinterface

// File: rtl/ws2812_stream_driver.sv
// WS2812B strip transmitter fed by a one-pixel-at-a-time valid/ready stream.
// A one-entry prefetch buffer holds the next pixel (already dimmed and
// reordered to GRB) while the shifter serialises the current one, so frames of
// any length stream out back-to-back with no gap cycles between pixels.
// Every frame, complete or aborted on underrun, ends with a T_RET low gap.
module ws2812_stream_driver #(
    parameter int NUM_LEDS = 4,
    parameter int T_BIT    = 125,
    parameter int T0H      = 40,
    parameter int T1H      = 80,
    parameter int T_RET    = 5000
) (
    input  logic clk,
    input  logic reset,
    ws2812_stream_driver_if.slave bus
);

    localparam int CYC_MAX = (T_BIT > T_RET) ? T_BIT : T_RET;
    localparam int CYC_W   = $clog2(CYC_MAX);
    localparam int PIX_W   = $clog2(NUM_LEDS + 1);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WAIT_FIRST = 3'd1;
    localparam logic [2:0] ST_HIGH       = 3'd2;
    localparam logic [2:0] ST_LOW        = 3'd3;
    localparam logic [2:0] ST_RET        = 3'd4;

    // Last cycle index of each phase, relative to the phase's own start.
    localparam logic [CYC_W-1:0] HIGH0_LAST = CYC_W'(T0H - 1);
    localparam logic [CYC_W-1:0] HIGH1_LAST = CYC_W'(T1H - 1);
    localparam logic [CYC_W-1:0] LOW0_LAST  = CYC_W'(T_BIT - T0H - 1);
    localparam logic [CYC_W-1:0] LOW1_LAST  = CYC_W'(T_BIT - T1H - 1);
    localparam logic [CYC_W-1:0] RET_LAST   = CYC_W'(T_RET - 1);
    localparam logic [PIX_W-1:0] LAST_PIX   = PIX_W'(NUM_LEDS - 1);
    localparam logic [PIX_W-1:0] ALL_PIX    = PIX_W'(NUM_LEDS);

    logic [2:0]       state_reg, state_next;
    logic [CYC_W-1:0] cyc_cnt_reg, cyc_cnt_next;
    logic [4:0]       bit_cnt_reg, bit_cnt_next;
    logic [PIX_W-1:0] pix_cnt_reg, pix_cnt_next;
    logic [PIX_W-1:0] acc_cnt_reg, acc_cnt_next;
    logic [23:0]      buf_reg, buf_next;
    logic             buf_full_reg, buf_full_next;
    logic [23:0]      shift_reg, shift_next;
    logic             aborted_reg, aborted_next;
    logic             busy_reg, busy_next;
    logic             pix_ready_reg, pix_ready_next;
    logic             bit_out_reg, bit_out_next;
    logic             frame_done_reg, frame_done_next;
    logic             underrun_reg, underrun_next;

    logic             accept;
    logic [7:0]       dimmed_ch [0:2];
    logic [23:0]      grb_pixel;
    logic [CYC_W-1:0] high_last;
    logic [CYC_W-1:0] low_last;
    logic             in_stream;

    // Per-channel brightness shift; channel 0 = B, 1 = G, 2 = R.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dim
            assign dimmed_ch[gi] = bus.pixData[gi*8 +: 8] >> bus.dim;
        end
    endgenerate

    // Strip wire order is G, R, B.
    assign grb_pixel = {dimmed_ch[1], dimmed_ch[2], dimmed_ch[0]};
    assign accept    = bus.pixValid & pix_ready_reg;

    // Phase lengths follow the bit currently at the head of the shifter.
    assign high_last = shift_reg[23] ? HIGH1_LAST : HIGH0_LAST;
    assign low_last  = shift_reg[23] ? LOW1_LAST  : LOW0_LAST;

    // Next-state logic: frame sequencing, bit timing and buffer bookkeeping.
    always_comb begin
        state_next      = state_reg;
        cyc_cnt_next    = cyc_cnt_reg;
        bit_cnt_next    = bit_cnt_reg;
        pix_cnt_next    = pix_cnt_reg;
        acc_cnt_next    = acc_cnt_reg;
        buf_next        = buf_reg;
        buf_full_next   = buf_full_reg;
        shift_next      = shift_reg;
        aborted_next    = aborted_reg;
        busy_next       = busy_reg;
        bit_out_next    = bit_out_reg;
        frame_done_next = 1'b0;
        underrun_next   = 1'b0;

        // Acceptance only ever happens into an empty buffer, because
        // pixReady is low whenever the buffer is full.
        if (accept) begin
            buf_next      = grb_pixel;
            buf_full_next = 1'b1;
            acc_cnt_next  = acc_cnt_reg + 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                bit_out_next = 1'b0;
                if (bus.start) begin
                    state_next    = ST_WAIT_FIRST;
                    busy_next     = 1'b1;
                    cyc_cnt_next  = '0;
                    bit_cnt_next  = '0;
                    pix_cnt_next  = '0;
                    acc_cnt_next  = '0;
                    buf_full_next = 1'b0;
                    aborted_next  = 1'b0;
                end
            end

            ST_WAIT_FIRST: begin
                bit_out_next = 1'b0;
                if (buf_full_reg) begin
                    shift_next    = buf_reg;
                    buf_full_next = 1'b0;
                    bit_cnt_next  = 5'd23;
                    cyc_cnt_next  = '0;
                    bit_out_next  = 1'b1;
                    state_next    = ST_HIGH;
                end
            end

            ST_HIGH: begin
                if (cyc_cnt_reg == high_last) begin
                    state_next   = ST_LOW;
                    cyc_cnt_next = '0;
                    bit_out_next = 1'b0;
                end else begin
                    cyc_cnt_next = cyc_cnt_reg + 1'b1;
                end
            end

            ST_LOW: begin
                if (cyc_cnt_reg != low_last) begin
                    cyc_cnt_next = cyc_cnt_reg + 1'b1;
                end else if (bit_cnt_reg != 5'd0) begin
                    // Next bit of the same pixel.
                    bit_cnt_next = bit_cnt_reg - 1'b1;
                    shift_next   = {shift_reg[22:0], 1'b0};
                    cyc_cnt_next = '0;
                    bit_out_next = 1'b1;
                    state_next   = ST_HIGH;
                end else if (pix_cnt_reg == LAST_PIX) begin
                    state_next   = ST_RET;
                    cyc_cnt_next = '0;
                end else if (buf_full_reg) begin
                    // Seamless hand-over to the prefetched pixel.
                    shift_next    = buf_reg;
                    buf_full_next = 1'b0;
                    pix_cnt_next  = pix_cnt_reg + 1'b1;
                    bit_cnt_next  = 5'd23;
                    cyc_cnt_next  = '0;
                    bit_out_next  = 1'b1;
                    state_next    = ST_HIGH;
                end else begin
                    // Source fell behind: abort the frame but still latch.
                    // Anything captured on this very edge is discarded.
                    underrun_next = 1'b1;
                    aborted_next  = 1'b1;
                    buf_full_next = 1'b0;
                    state_next    = ST_RET;
                    cyc_cnt_next  = '0;
                end
            end

            ST_RET: begin
                bit_out_next = 1'b0;
                if (cyc_cnt_reg == RET_LAST) begin
                    state_next      = ST_IDLE;
                    cyc_cnt_next    = '0;
                    busy_next       = 1'b0;
                    frame_done_next = ~aborted_reg;
                end else begin
                    cyc_cnt_next = cyc_cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next   = ST_IDLE;
                busy_next    = 1'b0;
                bit_out_next = 1'b0;
            end
        endcase
    end

    // pixReady is registered: offer a slot while streaming, buffer empty and
    // the frame still has pixels left to collect.
    always_comb begin
        in_stream      = (state_next == ST_WAIT_FIRST) || (state_next == ST_HIGH) ||
                         (state_next == ST_LOW);
        pix_ready_next = in_stream && !buf_full_next && (acc_cnt_next < ALL_PIX);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            cyc_cnt_reg    <= '0;
            bit_cnt_reg    <= '0;
            pix_cnt_reg    <= '0;
            acc_cnt_reg    <= '0;
            buf_reg        <= '0;
            buf_full_reg   <= 1'b0;
            shift_reg      <= '0;
            aborted_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            pix_ready_reg  <= 1'b0;
            bit_out_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
            underrun_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cyc_cnt_reg    <= cyc_cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            pix_cnt_reg    <= pix_cnt_next;
            acc_cnt_reg    <= acc_cnt_next;
            buf_reg        <= buf_next;
            buf_full_reg   <= buf_full_next;
            shift_reg      <= shift_next;
            aborted_reg    <= aborted_next;
            busy_reg       <= busy_next;
            pix_ready_reg  <= pix_ready_next;
            bit_out_reg    <= bit_out_next;
            frame_done_reg <= frame_done_next;
            underrun_reg   <= underrun_next;
        end
    end

    assign bus.pixReady  = pix_ready_reg;
    assign bus.bitOut    = bit_out_reg;
    assign bus.busy      = busy_reg;
    assign bus.frameDone = frame_done_reg;
    assign bus.underrun  = underrun_reg;

endmodule

// File: tb/tb_ws2812_stream_driver.sv
// Bench for ws2812_stream_driver: drives frames through the pixel stream,
// records the serial line per cycle and compares it with a waveform built
// directly from the WS2812 bit rules.
module tb_ws2812_stream_driver;

    localparam int NL   = 2;
    localparam int TB_  = 10;
    localparam int T0   = 3;
    localparam int T1   = 7;
    localparam int TR   = 20;
    localparam int PCYC = 24 * TB_;
    localparam int TAIL = 30;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    ws2812_stream_driver_if bus();

    ws2812_stream_driver #(
        .NUM_LEDS(NL), .T_BIT(TB_), .T0H(T0), .T1H(T1), .T_RET(TR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [23:0] pix  [0:3];
    logic [1:0]  dims [0:3];

    // Observations from the last captured frame (k = 0 is the first high cycle).
    logic tr_bit [0:1023];
    int   tr_len, done_cnt, done_k, und_cnt, und_k, busy_fall_k, busy_rerise, rise_lat, pre_events;

    logic exp_bit [0:1023];
    int   exp_len;

    // Reference waveform: n_sent dimmed GRB pixels as T_BIT-long bit cells, then low.
    function automatic void build_model(input int n_sent, input int total);
        int p;
        logic [7:0]  r, g, b;
        logic [23:0] grb;
        int hi;
        p = 0;
        for (int i = 0; i < n_sent; i++) begin
            r   = pix[i][23:16] >> dims[i];
            g   = pix[i][15:8]  >> dims[i];
            b   = pix[i][7:0]   >> dims[i];
            grb = {g, r, b};
            for (int j = 23; j >= 0; j--) begin
                hi = grb[j] ? T1 : T0;
                for (int c = 0; c < TB_; c++) begin
                    exp_bit[p] = (c < hi);
                    p++;
                end
            end
        end
        while (p < total) begin
            exp_bit[p] = 1'b0;
            p++;
        end
        exp_len = total;
    endfunction

    function automatic int trace_mismatch(output int first);
        int n;
        logic obs;
        n = 0;
        first = -1;
        for (int i = 0; i < exp_len; i++) begin
            obs = (i < tr_len) ? tr_bit[i] : 1'bx;
            if (obs !== exp_bit[i]) begin
                n++;
                if (first < 0) first = i;
            end
        end
        return n;
    endfunction

    // Starts a frame, feeds up to `fed` pixels, optionally pulses start at
    // frame offsets s1/s2, and records the line for `total` cycles after the
    // first rising edge (bounded if the line never rises).
    task automatic capture(input int fed, input int s1, input int s2, input int total);
        int  idx;
        bit  acc_pending;
        int  k;
        int  first_acc;
        idx = 0; acc_pending = 0; k = -1; first_acc = -1;
        done_cnt = 0; done_k = -1; und_cnt = 0; und_k = -1;
        busy_fall_k = -1; busy_rerise = 0; rise_lat = -1; pre_events = 0; tr_len = 0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < total + 100; c++) begin
            if (k < 0 && bus.bitOut === 1'b1) begin
                k = 0;
                rise_lat = c - first_acc;
            end
            if (k >= 0) begin
                tr_bit[k] = bus.bitOut;
                if (bus.frameDone === 1'b1) begin done_cnt++; if (done_k < 0) done_k = k; end
                if (bus.underrun === 1'b1) begin und_cnt++; if (und_k < 0) und_k = k; end
                if (busy_fall_k < 0 && bus.busy !== 1'b1) busy_fall_k = k;
                else if (busy_fall_k >= 0 && bus.busy === 1'b1) busy_rerise++;
                tr_len = k + 1;
            end else if (bus.frameDone === 1'b1 || bus.underrun === 1'b1) begin
                pre_events++;
            end
            if (acc_pending) idx++;
            bus.pixValid = (idx < fed);
            bus.pixData  = (idx < fed) ? pix[idx] : 24'h0;
            bus.dim      = (idx < fed) ? dims[idx] : 2'd0;
            acc_pending  = bus.pixValid && (bus.pixReady === 1'b1);
            if (acc_pending && first_acc < 0) first_acc = c;
            bus.start = (k >= 0) && (k == s1 || k == s2);
            if (k >= 0) k++;
            if (k >= total) break;
            @(negedge clk);
        end
        bus.start    = 1'b0;
        bus.pixValid = 1'b0;
        $display("frame: fed=%0d recorded=%0d rise_lat=%0d frameDone@%0d x%0d underrun@%0d x%0d busy_fall@%0d",
                 fed, tr_len, rise_lat, done_k, done_cnt, und_k, und_cnt, busy_fall_k);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.start = 1'b1;
        bus.pixValid = 1'b1;
        bus.pixData = 24'hA5C3_5A;
        bus.dim = 2'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.bitOut, bus.busy, bus.pixReady, bus.frameDone, bus.underrun} !== 5'b0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got bitOut/busy/pixReady/frameDone/underrun=%b, required 00000",
                         i, {bus.bitOut, bus.busy, bus.pixReady, bus.frameDone, bus.underrun});
            end
        end
        bus.start = 1'b0;
        bus.pixValid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_full_frame();
        int mm, first;
        pix[0] = 24'hFF0000; dims[0] = 2'd0;
        pix[1] = 24'h00FF00; dims[1] = 2'd0;
        capture(NL, -1, -1, NL*PCYC + TR + TAIL);
        build_model(NL, NL*PCYC + TR + TAIL);
        mm = trace_mismatch(first);
        checks++;
        if (mm !== 0) begin errors++; $display("FAIL full_trace: %0d bad cycles (first at %0d), required 0", mm, first); end
        checks++;
        if (rise_lat !== 2) begin errors++; $display("FAIL full_first_latency: got %0d, required 2", rise_lat); end
        checks++;
        if (done_k !== NL*PCYC + TR || done_cnt !== 1) begin
            errors++; $display("FAIL full_frameDone: got @%0d x%0d, required @%0d x1", done_k, done_cnt, NL*PCYC + TR);
        end
        checks++;
        if (busy_fall_k !== NL*PCYC + TR || busy_rerise !== 0) begin
            errors++; $display("FAIL full_busy: fell @%0d rerise %0d, required @%0d rerise 0", busy_fall_k, busy_rerise, NL*PCYC + TR);
        end
        checks++;
        if (und_cnt !== 0 || pre_events !== 0) begin
            errors++; $display("FAIL full_no_underrun: underrun x%0d stray %0d, required 0", und_cnt, pre_events);
        end
    endtask

    task automatic test_dimming();
        int mm, first, long_cnt, short_cnt, hi;
        pix[0] = 24'hFFFFFF; dims[0] = 2'd2;
        pix[1] = 24'hFFFFFF; dims[1] = 2'd2;
        capture(NL, -1, -1, NL*PCYC + TR + 5);
        build_model(NL, NL*PCYC + TR + 5);
        mm = trace_mismatch(first);
        checks++;
        if (mm !== 0) begin errors++; $display("FAIL dim_trace: %0d bad cycles (first at %0d), required 0", mm, first); end
        long_cnt = 0; short_cnt = 0;
        for (int j = 0; j < NL*24; j++) begin
            hi = 0;
            for (int c = 0; c < TB_; c++) if (j*TB_ + c < tr_len && tr_bit[j*TB_ + c] === 1'b1) hi++;
            if (hi == T1) long_cnt++;
            else if (hi == T0) short_cnt++;
        end
        checks++;
        if (long_cnt !== NL*18 || short_cnt !== NL*6) begin
            errors++; $display("FAIL dim_high_times: got %0d long %0d short, required %0d long %0d short",
                               long_cnt, short_cnt, NL*18, NL*6);
        end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL dim_frameDone: got x%0d, required x1", done_cnt); end
    endtask

    task automatic test_underrun();
        int mm, first;
        pix[0] = $urandom & 24'hFFFFFF; dims[0] = 2'($urandom_range(0, 3));
        pix[1] = $urandom & 24'hFFFFFF; dims[1] = 2'd0;
        capture(1, -1, -1, PCYC + TR + TAIL);
        build_model(1, PCYC + TR + TAIL);
        mm = trace_mismatch(first);
        checks++;
        if (mm !== 0) begin errors++; $display("FAIL underrun_trace: %0d bad cycles (first at %0d), required 0", mm, first); end
        checks++;
        if (und_k !== PCYC || und_cnt !== 1) begin
            errors++; $display("FAIL underrun_pulse: got @%0d x%0d, required @%0d x1", und_k, und_cnt, PCYC);
        end
        checks++;
        if (done_cnt !== 0) begin errors++; $display("FAIL underrun_no_frameDone: got x%0d, required x0", done_cnt); end
        checks++;
        if (busy_fall_k !== PCYC + TR) begin
            errors++; $display("FAIL underrun_busy: fell @%0d, required @%0d", busy_fall_k, PCYC + TR);
        end
        checks++;
        if (bus.pixReady !== 1'b0) begin errors++; $display("FAIL underrun_pixReady_idle: got %b, required 0", bus.pixReady); end
    endtask

    task automatic test_ignored_start();
        int mm, first;
        pix[0] = $urandom & 24'hFFFFFF; dims[0] = 2'd0;
        pix[1] = $urandom & 24'hFFFFFF; dims[1] = 2'd1;
        capture(NL, 100, NL*PCYC + TR - 1, NL*PCYC + TR + TAIL);
        build_model(NL, NL*PCYC + TR + TAIL);
        mm = trace_mismatch(first);
        checks++;
        if (mm !== 0) begin errors++; $display("FAIL ignstart_trace: %0d bad cycles (first at %0d), required 0", mm, first); end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL ignstart_frameDone: got x%0d, required x1", done_cnt); end
        checks++;
        if (busy_fall_k !== NL*PCYC + TR || busy_rerise !== 0) begin
            errors++; $display("FAIL ignstart_busy: fell @%0d rerise %0d, required @%0d rerise 0", busy_fall_k, busy_rerise, NL*PCYC + TR);
        end
    endtask

    task automatic test_mid_reset();
        int mm, first;
        bus.pixValid = 1'b1;
        bus.pixData  = 24'hFFFFFF;
        bus.dim      = 2'd0;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 20 && bus.bitOut !== 1'b1; c++) @(negedge clk);
        checks++;
        if (bus.bitOut !== 1'b1) begin errors++; $display("FAIL midreset_rise: bitOut %b, required 1", bus.bitOut); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.bitOut !== 1'b0) begin errors++; $display("FAIL midreset_bitOut: got %b, required 0", bus.bitOut); end
        checks++;
        if (bus.busy !== 1'b0 || bus.pixReady !== 1'b0) begin
            errors++; $display("FAIL midreset_flags: busy %b pixReady %b, required 0 0", bus.busy, bus.pixReady);
        end
        reset = 1'b1;
        bus.pixValid = 1'b0;
        repeat (2) @(negedge clk);
        pix[0] = $urandom & 24'hFFFFFF; dims[0] = 2'($urandom_range(0, 3));
        pix[1] = $urandom & 24'hFFFFFF; dims[1] = 2'($urandom_range(0, 3));
        capture(NL, -1, -1, NL*PCYC + TR + 5);
        build_model(NL, NL*PCYC + TR + 5);
        mm = trace_mismatch(first);
        checks++;
        if (mm !== 0) begin errors++; $display("FAIL midreset_frame: %0d bad cycles (first at %0d), required 0", mm, first); end
        checks++;
        if (done_k !== NL*PCYC + TR) begin errors++; $display("FAIL midreset_frameDone: got @%0d, required @%0d", done_k, NL*PCYC + TR); end
    endtask

    task automatic test_random_frames();
        int mm, first;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < NL; i++) begin
                pix[i]  = $urandom & 24'hFFFFFF;
                dims[i] = 2'($urandom_range(0, 3));
            end
            repeat ($urandom_range(0, 4)) @(negedge clk);
            capture(NL, -1, -1, NL*PCYC + TR + 5);
            build_model(NL, NL*PCYC + TR + 5);
            mm = trace_mismatch(first);
            checks++;
            if (mm !== 0) begin errors++; $display("FAIL random_trace %0d: %0d bad cycles (first at %0d), required 0", f, mm, first); end
            checks++;
            if (rise_lat !== 2) begin errors++; $display("FAIL random_latency %0d: got %0d, required 2", f, rise_lat); end
            checks++;
            if (done_k !== NL*PCYC + TR || done_cnt !== 1 || und_cnt !== 0) begin
                errors++; $display("FAIL random_done %0d: frameDone @%0d x%0d underrun x%0d, required @%0d x1 x0",
                                   f, done_k, done_cnt, und_cnt, NL*PCYC + TR);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.pixValid = 1'b0;
        bus.pixData = 24'h0;
        bus.dim = 2'd0;
        test_reset();
        test_full_frame();
        test_dimming();
        test_underrun();
        test_ignored_start();
        test_mid_reset();
        test_random_frames();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
